// File: rtl/io_pad_sync_ice40.sv
// Clocked, turnaround-safe muxable IO pad for iCE40 (sits between SB_IO
// and peripheral cores).
//
// Ports:
//   clk           - system clock, rising edge
//   rst_n         - asynchronous reset, active low; releases the pin at once
//   pin           - package pin (through SB_IO with unregistered OE/out/in)
//   func_select   - requested function; RX codes 0..RXCOUNT-1,
//                   TX codes RXCOUNT..RXCOUNT+TXCOUNT-1, higher codes park
//   func_transmit - per-TX-function value to drive
//   func_receive  - per-RX-function filtered pin value, 0 when not active
//   rx_rise       - 1-cycle pulse on filtered 0->1 while an RX code is active
//   rx_fall       - 1-cycle pulse on filtered 1->0 while an RX code is active
//   busy          - high while a function switch is in progress
module io_pad_sync_ice40 #(
    parameter int TXCOUNT     = 2,
    parameter int RXCOUNT     = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int TURNAROUND  = 2,
    localparam int MUXWIDTH   = $clog2(TXCOUNT + RXCOUNT)
) (
    input  logic                clk,
    input  logic                rst_n,
    inout  wire                 pin,
    input  logic [MUXWIDTH-1:0] func_select,
    input  logic [TXCOUNT-1:0]  func_transmit,
    output logic [RXCOUNT-1:0]  func_receive,
    output logic                rx_rise,
    output logic                rx_fall,
    output logic                busy
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (TXCOUNT < 1) begin : g_bad_txcount
        $error("io_pad_sync_ice40: TXCOUNT must be >= 1");
    end

    if (RXCOUNT < 1) begin : g_bad_rxcount
        $error("io_pad_sync_ice40: RXCOUNT must be >= 1");
    end

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("io_pad_sync_ice40: SYNC_STAGES must be >= 2");
    end

    if (FILTER_LEN < 1) begin : g_bad_filter
        $error("io_pad_sync_ice40: FILTER_LEN must be >= 1");
    end

    if (TURNAROUND < 1) begin : g_bad_turn
        $error("io_pad_sync_ice40: TURNAROUND must be >= 1");
    end

    // ------------------------------------------------------------------
    // Local widths and constants
    // ------------------------------------------------------------------
    localparam int CW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    localparam logic [CW-1:0] CNT_INIT = CW'(TURNAROUND - 1);
    localparam logic [FW-1:0] FCNT_TOP = FW'(FILTER_LEN - 1);

    typedef enum logic {
        TURN,
        ACTIVE
    } state_t;

    // ------------------------------------------------------------------
    // Selection state
    // ------------------------------------------------------------------
    state_t              state_q;
    state_t              state_d;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_d;
    logic [MUXWIDTH-1:0] pend_q;
    logic [MUXWIDTH-1:0] pend_d;
    logic [MUXWIDTH-1:0] sel_q;
    logic [MUXWIDTH-1:0] sel_d;

    // Pad drive flops
    logic oe_q;
    logic oe_d;
    logic dout_q;
    logic dout_d;

    // Whether the next selection is an RX code while ACTIVE
    logic rx_on_d;

    // ------------------------------------------------------------------
    // Input path state
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   filt_q;
    logic [FW-1:0]          fcnt_q;
    logic                   differ;
    logic                   fire;
    logic                   rise_q;
    logic                   fall_q;

    // ------------------------------------------------------------------
    // Pad
    // ------------------------------------------------------------------
    assign pin = oe_q ? dout_q : 1'bz;

    // ------------------------------------------------------------------
    // Selection FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TURN;
            cnt_q   <= CNT_INIT;
            pend_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
        end
    end

    // ------------------------------------------------------------------
    // Selection FSM: next state
    // A switch only completes once the request has held still for
    // TURNAROUND samples; any change in between restarts the gap.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        sel_d   = sel_q;

        unique case (state_q)
            TURN: begin
                pend_d = func_select;
                if (func_select != pend_q) begin
                    cnt_d = CNT_INIT;
                end else if (cnt_q == '0) begin
                    state_d = ACTIVE;
                    sel_d   = func_select;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ACTIVE: begin
                if (func_select != sel_q) begin
                    state_d = TURN;
                    cnt_d   = CNT_INIT;
                    pend_d  = func_select;
                end
            end

            default: begin
                state_d = TURN;
                cnt_d   = CNT_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state/selection, so the pad flops and
    // the FSM change on the same edge and the Z gap is exact.
    // ------------------------------------------------------------------
    always_comb begin
        oe_d    = 1'b0;
        dout_d  = 1'b0;
        rx_on_d = 1'b0;

        for (int i = 0; i < TXCOUNT; i++) begin
            if (int'(sel_d) == RXCOUNT + i) begin
                dout_d = func_transmit[i];
                oe_d   = (state_d == ACTIVE);
            end
        end

        for (int i = 0; i < RXCOUNT; i++) begin
            if (int'(sel_d) == i) begin
                rx_on_d = (state_d == ACTIVE);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oe_q   <= 1'b0;
            dout_q <= 1'b0;
        end else begin
            oe_q   <= oe_d;
            dout_q <= dout_d;
        end
    end

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Glitch filter: a new level is accepted only after it has been seen
    // on FILTER_LEN consecutive samples. Runs regardless of selection,
    // so own drive is also read back here.
    // ------------------------------------------------------------------
    assign differ = (sync_out != filt_q);
    assign fire   = differ && (fcnt_q == FCNT_TOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else if (!differ) begin
            fcnt_q <= '0;
        end else if (fire) begin
            filt_q <= ~filt_q;
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Edge pulses, aligned with the cycle filtered shows the new level.
    // Qualified with the next selection so a pulse never appears while
    // func_receive is forced to 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= fire && !filt_q && rx_on_d;
            fall_q <= fire && filt_q && rx_on_d;
        end
    end

    assign rx_rise = rise_q;
    assign rx_fall = fall_q;

    // ------------------------------------------------------------------
    // Receive fan-out and status
    // ------------------------------------------------------------------
    always_comb begin
        func_receive = '0;
        for (int i = 0; i < RXCOUNT; i++) begin
            if (state_q == ACTIVE && int'(sel_q) == i) begin
                func_receive[i] = filt_q;
            end
        end
    end

    assign busy = (state_q != ACTIVE);

endmodule

// File: tb/tb_io_pad_sync_ice40.sv
// Self-checking bench for io_pad_sync_ice40: an abstract model of the pad
// is compared every cycle, plus directed checks with literal expectations.
module tb_io_pad_sync_ice40;

    localparam int TX   = 2;
    localparam int RX   = 2;
    localparam int SYNC = 2;
    localparam int FL   = 3;
    localparam int TA   = 2;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] fs = 2'd2;
    logic [1:0] ft = 2'b01;
    logic [1:0] fr;
    logic       rise;
    logic       fall;
    logic       busy;
    logic       ext_val = 1'b1;
    logic       ext_en = 1'b1;
    wire        pin;

    // Second pad: RX=2, TX=1, used for the out-of-range code
    logic [1:0] fs2 = 2'd3;
    logic [0:0] ft2 = 1'b1;
    logic [1:0] fr2;
    logic       rise2;
    logic       fall2;
    logic       busy2;
    logic       ext2 = 1'b0;
    logic       ext2_en = 1'b1;
    wire        pin2;

    int n_cmp = 0;
    int n_bad = 0;

    assign pin  = ext_en ? ext_val : 1'bz;
    assign pin2 = ext2_en ? ext2 : 1'bz;

    io_pad_sync_ice40 #(
        .TXCOUNT(TX), .RXCOUNT(RX), .SYNC_STAGES(SYNC),
        .FILTER_LEN(FL), .TURNAROUND(TA)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .pin(pin),
        .func_select(fs), .func_transmit(ft),
        .func_receive(fr), .rx_rise(rise), .rx_fall(fall),
        .busy(busy)
    );

    io_pad_sync_ice40 #(
        .TXCOUNT(1), .RXCOUNT(2), .SYNC_STAGES(2),
        .FILTER_LEN(3), .TURNAROUND(2)
    ) u_oor (
        .clk(clk), .rst_n(rst_n), .pin(pin2),
        .func_select(fs2), .func_transmit(ft2),
        .func_receive(fr2), .rx_rise(rise2), .rx_fall(fall2),
        .busy(busy2)
    );

    initial begin
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Abstract model
    //   Selection: a function becomes active once the sampled request has
    //   stayed equal to its previous sample TA times in a row (the sample
    //   before reset counts as code 0); any change while active drops it.
    //   Input: pin seen SYNC samples late; the filtered level flips after
    //   FL consecutive disagreeing samples.
    // ------------------------------------------------------------------
    bit              m_active = 0;
    int              m_sel = 0;
    int              m_prev = 0;
    int              m_stable = 0;
    bit              m_oe = 0;
    bit              m_dout = 0;
    bit [SYNC-1:0]   hist = '0;
    bit              m_filt = 0;
    int              m_run = 0;
    bit              m_rise = 0;
    bit              m_fall = 0;

    initial begin
        bit cur;
        bit fin;
        bit tog;
        bit rx_on;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active = 0; m_sel = 0; m_prev = 0; m_stable = 0;
                m_oe = 0; m_dout = 0; hist = '0; m_filt = 0;
                m_run = 0; m_rise = 0; m_fall = 0;
                ext_en <= 1'b1;
            end else begin
                cur = m_oe ? m_dout : ext_val;
                fin = hist[SYNC-1];
                hist = {hist[SYNC-2:0], cur};
                tog = 0;
                if (fin != m_filt) begin
                    m_run++;
                    if (m_run == FL) begin
                        m_filt = ~m_filt;
                        m_run = 0;
                        tog = 1;
                    end
                end else begin
                    m_run = 0;
                end
                if (m_active) begin
                    if (int'(fs) != m_sel) begin
                        m_active = 0;
                        m_stable = 0;
                        m_prev = int'(fs);
                    end
                end else begin
                    if (int'(fs) != m_prev) m_stable = 0;
                    else m_stable++;
                    m_prev = int'(fs);
                    if (m_stable >= TA) begin
                        m_active = 1;
                        m_sel = int'(fs);
                    end
                end
                rx_on = m_active && m_sel < RX;
                m_rise = tog && m_filt && rx_on;
                m_fall = tog && !m_filt && rx_on;
                m_oe = m_active && m_sel >= RX && m_sel < RX + TX;
                m_dout = m_oe ? ft[m_sel-RX] : 1'b0;
                ext_en <= !m_oe;
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        logic [1:0] efr;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                efr = '0;
                if (m_active && m_sel < RX && m_filt) efr[m_sel] = 1'b1;
                chk("m_busy", busy, !m_active);
                chk("m_rx", fr, efr);
                chk("m_rise", rise, m_rise);
                chk("m_fall", fall, m_fall);
                chk("m_pin", pin, m_oe ? m_dout : ext_val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    task automatic release_check(input string tag);
        @(negedge clk);
        chk({tag, "_busy1"}, busy, 1);
        chk({tag, "_z1"}, pin, 0);
        @(negedge clk);
        chk({tag, "_busy2"}, busy, 1);
        chk({tag, "_z2"}, pin, 0);
        @(negedge clk);
        chk({tag, "_busy3"}, busy, 0);
        chk({tag, "_tx"}, pin, 1);
    endtask

    initial begin
        int  n;
        bit  seen;
        bit  found;

        // Reset with the clock running
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_rx", fr, 0);
        chk("rst_pulse", {rise, fall}, 0);
        chk("rst_pin_z", pin, 1);
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ext_val = 1'b0;
        release_check("rel");

        // TX latency of one clock
        ft = 2'b00;
        @(negedge clk);
        chk("tx_lat0", pin, 0);
        ft = 2'b01;
        @(negedge clk);
        chk("tx_lat1", pin, 1);

        // TX0 -> RX0 switch while driving 1
        fs = 2'd0;
        ext_val = 1'b0;
        @(negedge clk);
        chk("sw_z", pin, 0);
        chk("sw_busy1", busy, 1);
        @(negedge clk);
        chk("sw_busy2", busy, 1);
        @(negedge clk);
        chk("sw_busy3", busy, 0);
        repeat (8) @(negedge clk);
        chk("sw_rx_lo", fr, 2'b00);
        ext_val = 1'b1;
        repeat (8) @(negedge clk);
        chk("sw_rx_hi", fr, 2'b01);
        ext_val = 1'b0;
        repeat (8) @(negedge clk);
        chk("sw_rx_lo2", fr, 2'b00);

        // Two-cycle glitch is suppressed
        ext_val = 1'b1;
        repeat (2) @(negedge clk);
        ext_val = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            seen |= rise | fall | fr[0];
        end
        chk("glitch", seen, 0);

        // Held step: visible on the edge SYNC+FL after the change
        ext_val = 1'b1;
        n = 0;
        found = 0;
        for (int i = 1; i <= 10 && !found; i++) begin
            @(negedge clk);
            if (fr[0]) begin
                found = 1;
                n = i;
                chk("rise_pulse", rise, 1);
            end
        end
        chk("rise_edge", n, 5);
        @(negedge clk);
        chk("rise_single", rise, 0);

        ext_val = 1'b0;
        n = 0;
        found = 0;
        for (int i = 1; i <= 10 && !found; i++) begin
            @(negedge clk);
            if (!fr[0]) begin
                found = 1;
                n = i;
                chk("fall_pulse", fall, 1);
            end
        end
        chk("fall_edge", n, 5);
        @(negedge clk);
        chk("fall_single", fall, 0);

        // Select bouncing 0 -> 2 -> 0 -> 1
        ft = 2'b01;
        fs = 2'd2;
        @(negedge clk);
        chk("bn_busy_a", busy, 1);
        chk("bn_z_a", pin, 0);
        fs = 2'd0;
        @(negedge clk);
        chk("bn_busy_b", busy, 1);
        chk("bn_z_b", pin, 0);
        fs = 2'd1;
        @(negedge clk);
        chk("bn_busy_c", busy, 1);
        @(negedge clk);
        chk("bn_busy_d", busy, 1);
        chk("bn_z_d", pin, 0);
        @(negedge clk);
        chk("bn_busy_e", busy, 0);
        chk("bn_rx", fr, 2'b00);
        ext_val = 1'b1;
        repeat (8) @(negedge clk);
        chk("bn_rx1", fr, 2'b10);
        ext_val = 1'b0;
        repeat (8) @(negedge clk);

        // Out-of-range code on the RX=2/TX=1 pad
        chk("oor_busy", busy2, 0);
        chk("oor_z", pin2, 0);
        chk("oor_rx", fr2, 0);
        ext2 = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            seen |= rise2 | fall2 | fr2[0] | fr2[1];
        end
        chk("oor_rx_hi", seen, 0);

        // Asynchronous reset mid-drive with the clock stopped
        fs = 2'd3;
        ft = 2'b10;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (!busy) found = 1;
        end
        chk("ar_reach", found, 1);
        @(negedge clk);
        chk("ar_drive", pin, 1);
        clk_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_z", pin, 0);
        chk("ar_busy", busy, 1);
        chk("ar_rx", fr, 0);
        chk("ar_pulse", {rise, fall}, 0);
        #10;
        fs = 2'd2;
        ft = 2'b01;
        rst_n = 1'b1;
        #3;
        clk_en = 1'b1;
        release_check("rec");

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
